int_div_32: RTL and testbench

Multi-cycle 32-bit integer divider: the responder side of the start/valid divide handshake that the ALU drives for RISC-V DIV, DIVU, REM and REMU. It accepts operands and per-operand signedness on a start strobe, runs a radix-2 restoring division, and returns quotient and remainder with a valid pulse. Its ports match the ALU's divider instance, so it drops into the execute stage as the divide unit.

---
 rtl/int_div_32.sv | 122 ++++++++++++
 tb/tb_int_div_32.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/int_div_32.sv
// Multi-cycle radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Start/valid handshake; 34-cycle latency, 1 cycle for divide-by-zero and signed overflow.
module int_div_32 #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start_num_is_signed,
    input  logic              start_den_is_signed,
    input  logic [DATA_W-1:0] start_num,
    input  logic [DATA_W-1:0] start_den,
    input  logic              EN_start,
    output logic              RDY_start,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_quo,
    output logic [DATA_W-1:0] result_rem,
    output logic              RDY_result_rem
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, state_nxt;
    logic [4:0]        cnt;
    logic [DATA_W:0]   rem_r;
    logic [DATA_W-1:0] quo_r;
    logic [DATA_W-1:0] den_r;
    logic              neg_q, neg_r;

    logic              accept;
    logic              num_neg, den_neg;
    logic [DATA_W-1:0] num_abs, den_abs;
    logic              div0, ovf, special;
    logic [DATA_W:0]   trial;

    assign RDY_start = (state == IDLE) || (state == DONE);
    assign accept    = EN_start && RDY_start;

    assign num_neg = start_num_is_signed && start_num[DATA_W-1];
    assign den_neg = start_den_is_signed && start_den[DATA_W-1];
    assign num_abs = num_neg ? -start_num : start_num;
    assign den_abs = den_neg ? -start_den : start_den;
    assign div0    = (start_den == '0);
    assign ovf     = start_num_is_signed && start_den_is_signed &&
                     (start_num == {1'b1, {(DATA_W-1){1'b0}}}) && (start_den == '1);
    assign special = div0 || ovf;

    // Shifted partial remainder minus divisor; bit DATA_W set means it went negative.
    assign trial = {rem_r[DATA_W-1:0], quo_r[DATA_W-1]} - {1'b0, den_r};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_nxt = special ? DONE : CALC;
                else
                    state_nxt = IDLE;
            end
            CALC:    if (cnt == 5'd31) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state          <= IDLE;
            cnt            <= '0;
            rem_r          <= '0;
            quo_r          <= '0;
            den_r          <= '0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            result_valid   <= 1'b0;
            result_quo     <= '0;
            result_rem     <= '0;
            RDY_result_rem <= 1'b0;
        end else begin
            state        <= state_nxt;
            result_valid <= (state_nxt == DONE);
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        cnt            <= '0;
                        rem_r          <= '0;
                        quo_r          <= num_abs;
                        den_r          <= den_abs;
                        neg_q          <= num_neg ^ den_neg;
                        neg_r          <= num_neg;
                        RDY_result_rem <= 1'b0;
                        if (div0) begin
                            result_quo     <= '1;
                            result_rem     <= start_num;
                            RDY_result_rem <= 1'b1;
                        end else if (ovf) begin
                            result_quo     <= {1'b1, {(DATA_W-1){1'b0}}};
                            result_rem     <= '0;
                            RDY_result_rem <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    if (!trial[DATA_W]) begin
                        rem_r <= trial;
                        quo_r <= {quo_r[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_r <= {rem_r[DATA_W-1:0], quo_r[DATA_W-1]};
                        quo_r <= {quo_r[DATA_W-2:0], 1'b0};
                    end
                end
                FIX: begin
                    result_quo     <= neg_q ? -quo_r : quo_r;
                    result_rem     <= neg_r ? -rem_r[DATA_W-1:0] : rem_r[DATA_W-1:0];
                    RDY_result_rem <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_div_32.sv
// Directed bench for int_div_32: hand-computed quotient/remainder/latency vectors.
module tb_int_div_32;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        start_num_is_signed, start_den_is_signed;
    logic [31:0] start_num, start_den;
    logic        EN_start;
    logic        RDY_start, result_valid, RDY_result_rem;
    logic [31:0] result_quo, result_rem;

    int nvec = 0;
    int nerr = 0;

    int_div_32 dut (
        .CLK                 (CLK),
        .RST_N               (RST_N),
        .start_num_is_signed (start_num_is_signed),
        .start_den_is_signed (start_den_is_signed),
        .start_num           (start_num),
        .start_den           (start_den),
        .EN_start            (EN_start),
        .RDY_start           (RDY_start),
        .result_valid        (result_valid),
        .result_quo          (result_quo),
        .result_rem          (result_rem),
        .RDY_result_rem      (RDY_result_rem)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives a start strobe across one edge; caller is then in the cycle after edge 0.
    task automatic launch(input logic [31:0] n, input logic [31:0] d, input logic ns, input logic ds);
        start_num = n; start_den = d;
        start_num_is_signed = ns; start_den_is_signed = ds;
        EN_start = 1'b1;
        tick();
        EN_start = 1'b0;
        start_num = 32'hDEAD_BEEF; start_den = 32'h0BAD_F00D;
    endtask

    // lat0 is the latency count of the current cycle; stops in the valid (DONE) cycle.
    task automatic wait_result(input string tag, input int lat0, input int exp_lat,
                               input logic [31:0] eq, input logic [31:0] er);
        int lat = lat0;
        while (!result_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " quo"}, result_quo, eq);
        chk({tag, " rem"}, result_rem, er);
        chk({tag, " rdy_rem"}, {31'b0, RDY_result_rem}, 32'd1);
    endtask

    initial begin
        RST_N = 1'b0; EN_start = 1'b0;
        start_num = '0; start_den = '0;
        start_num_is_signed = 1'b0; start_den_is_signed = 1'b0;
        repeat (3) tick();
        chk("reset valid", {31'b0, result_valid}, 32'd0);
        chk("reset quo", result_quo, 32'd0);
        chk("reset rem", result_rem, 32'd0);
        chk("reset rdy_rem", {31'b0, RDY_result_rem}, 32'd0);
        chk("reset rdy_start", {31'b0, RDY_start}, 32'd1);
        RST_N = 1'b1;
        tick();

        launch(32'd100, 32'd7, 1'b0, 1'b0);
        chk("busy rdy_start", {31'b0, RDY_start}, 32'd0);
        wait_result("u100/7", 1, 34, 32'd14, 32'd2);
        repeat (3) tick();
        chk("hold rdy_rem", {31'b0, RDY_result_rem}, 32'd1);
        chk("hold quo", result_quo, 32'd14);
        chk("hold valid", {31'b0, result_valid}, 32'd0);

        launch(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1);
        wait_result("s-100/7", 1, 34, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        tick();
        launch(32'd100, 32'hFFFF_FFF9, 1'b1, 1'b1);
        wait_result("s100/-7", 1, 34, 32'hFFFF_FFF2, 32'd2);
        tick();
        launch(32'h1234_5678, 32'd0, 1'b1, 1'b1);
        wait_result("sdiv0", 1, 1, 32'hFFFF_FFFF, 32'h1234_5678);
        tick();
        launch(32'h1234_5678, 32'd0, 1'b0, 1'b0);
        wait_result("udiv0", 1, 1, 32'hFFFF_FFFF, 32'h1234_5678);
        tick();
        launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        wait_result("sovf", 1, 1, 32'h8000_0000, 32'd0);
        tick();
        launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_result("uovf", 1, 34, 32'd0, 32'h8000_0000);
        tick();
        launch(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        wait_result("umax/1", 1, 34, 32'hFFFF_FFFF, 32'd0);
        tick();

        // Strobe mid-CALC must be ignored.
        launch(32'd100, 32'd7, 1'b0, 1'b0);
        repeat (8) tick();
        start_num = 32'd9; start_den = 32'd3; EN_start = 1'b1;
        tick();
        EN_start = 1'b0;
        wait_result("ignored", 10, 34, 32'd14, 32'd2);
        // Back-to-back: strobe in the DONE cycle.
        launch(32'd9, 32'd3, 1'b0, 1'b0);
        wait_result("b2b 9/3", 1, 34, 32'd3, 32'd0);
        tick();

        // Reset mid-operation, with a simultaneous strobe that must be dropped.
        launch(32'd100, 32'd7, 1'b0, 1'b0);
        repeat (19) tick();
        RST_N = 1'b0;
        start_num = 32'd9; start_den = 32'd0; EN_start = 1'b1;
        tick();
        RST_N = 1'b1; EN_start = 1'b0;
        chk("midrst valid", {31'b0, result_valid}, 32'd0);
        chk("midrst rdy_start", {31'b0, RDY_start}, 32'd1);
        chk("midrst rdy_rem", {31'b0, RDY_result_rem}, 32'd0);
        chk("midrst quo", result_quo, 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (result_valid) seen++;
            end
            chk("no valid after reset", 32'(seen), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
